// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit_pkg
// Brief  : Shared core constants for the fetch stage (states, NOP, reset PC).
// Rev    : 1.0
// ============================================================================
package fetch_unit_pkg;

    typedef logic [0:0] fetch_state_t;

    localparam fetch_state_t S_FETCH = 1'b0;
    localparam fetch_state_t S_HOLD  = 1'b1;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Next-PC mux select encoding
    localparam logic [1:0] NPC_KEEP   = 2'd0;
    localparam logic [1:0] NPC_SEQ    = 2'd1;
    localparam logic [1:0] NPC_TARGET = 2'd2;
    localparam logic [1:0] NPC_PEND   = 2'd3;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// Module : fetch_skid_buf
// Brief  : One-entry buffer holding a fetched {pc, instr} while IF/ID stalls.
// Rev    : 1.0
// ============================================================================
module fetch_skid_buf #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [width-1:0] pc_in,
    input  logic [width-1:0] instr_in,
    output logic             valid,
    output logic [width-1:0] pc,
    output logic [width-1:0] instr
);

    logic             valid_q, valid_d;
    logic [width-1:0] pc_q, pc_d;
    logic [width-1:0] instr_q, instr_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            instr_d = instr_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule : fetch_skid_buf
`default_nettype wire

// File: rtl/mux4.sv
`default_nettype none
// ============================================================================
// Module : mux4
// Brief  : Generic 4:1 multiplexer cell.
// Rev    : 1.0
// ============================================================================
module mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule : mux4
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch with IF/ID register, skid buffer and redirect.
// Rev    : 1.0
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               width    = 32,
    parameter logic [width-1:0] RESET_PC = width'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_F,
    input  logic             realBJ_D,
    input  logic [width-1:0] targetPC_D,
    output logic             imemReq,
    output logic [width-1:0] imemAddr,
    input  logic             imemReady,
    input  logic [width-1:0] imemData,
    output logic [width-1:0] pc_D,
    output logic [width-1:0] instr_D,
    output logic             valid_D
);

    fetch_state_t     state_q, state_d;
    logic [width-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [width-1:0] pend_pc_q, pend_pc_d;
    logic [width-1:0] ifid_pc_q, ifid_pc_d;
    logic [width-1:0] ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;

    logic [1:0]       npc_sel;
    logic             buf_load, buf_clear, buf_valid;
    logic [width-1:0] buf_pc, buf_instr;
    logic             redirect, in_fetch, accept;

    assign redirect = realBJ_D & ifid_valid_q & ~stall_F;
    assign in_fetch = (state_q == S_FETCH);
    assign accept   = in_fetch & imemReady & ~redirect & ~pend_valid_q;

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        npc_sel      = NPC_KEEP;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        if (redirect) begin
            ifid_pc_d    = '0;
            ifid_instr_d = width'(NOP_WORD);
            ifid_valid_d = 1'b0;
            if (!in_fetch) begin
                buf_clear = 1'b0 | 1'b1;
                state_d   = S_FETCH;
                npc_sel   = NPC_TARGET;
            end else if (imemReady) begin
                npc_sel      = NPC_TARGET;
                pend_valid_d = 1'b0;
            end else begin
                // Request still in flight: address must stay put until it completes
                pend_valid_d = 1'b1;
                pend_pc_d    = targetPC_D;
            end
        end else if (in_fetch && imemReady && pend_valid_q) begin
            ifid_pc_d    = '0;
            ifid_instr_d = width'(NOP_WORD);
            ifid_valid_d = 1'b0;
            npc_sel      = NPC_PEND;
            pend_valid_d = 1'b0;
        end else if (accept) begin
            npc_sel = NPC_SEQ;
            if (!stall_F) begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = imemData;
                ifid_valid_d = 1'b1;
            end else begin
                buf_load = 1'b1;
                state_d  = S_HOLD;
            end
        end else if (!in_fetch) begin
            if (!stall_F) begin
                ifid_pc_d    = buf_pc;
                ifid_instr_d = buf_instr;
                ifid_valid_d = buf_valid;
                buf_clear    = 1'b1;
                state_d      = S_FETCH;
            end
        end else if (!stall_F) begin
            ifid_pc_d    = '0;
            ifid_instr_d = width'(NOP_WORD);
            ifid_valid_d = 1'b0;
        end
    end

    mux4 #(.WIDTH(width)) u_npc_mux (
        .sel (npc_sel),
        .d0  (pc_q),
        .d1  (pc_q + width'(4)),
        .d2  (targetPC_D),
        .d3  (pend_pc_q),
        .y   (pc_d)
    );

    fetch_skid_buf #(.width(width)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load),
        .clear    (buf_clear),
        .pc_in    (pc_q),
        .instr_in (imemData),
        .valid    (buf_valid),
        .pc       (buf_pc),
        .instr    (buf_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= width'(NOP_WORD);
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    // Request drops immediately while reset is held
    assign imemReq  = rst_n & in_fetch;
    assign imemAddr = pc_q;
    assign pc_D     = ifid_pc_q;
    assign instr_D  = ifid_instr_q;
    assign valid_D  = ifid_valid_q;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Self-checking bench: directed vector table, reference model, reset.
// Rev    : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stall_F = 1'b0;
    logic         realBJ_D = 1'b0;
    logic [W-1:0] targetPC_D = '0;
    logic         imemReq;
    logic [W-1:0] imemAddr;
    logic         imemReady = 1'b0;
    logic [W-1:0] imemData = '0;
    logic [W-1:0] pc_D;
    logic [W-1:0] instr_D;
    logic         valid_D;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.width(W), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall_F    (stall_F),
        .realBJ_D   (realBJ_D),
        .targetPC_D (targetPC_D),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemData   (imemData),
        .pc_D       (pc_D),
        .instr_D    (instr_D),
        .valid_D    (valid_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch address, one-entry hold slot, pending redirect, IF/ID
    logic [31:0] m_pc, m_bpc, m_binstr, m_ppc, m_pcd, m_id;
    logic        m_hold, m_pend, m_vd;

    task automatic model_reset();
        m_pc = 32'h0; m_hold = 1'b0; m_bpc = '0; m_binstr = '0;
        m_pend = 1'b0; m_ppc = '0; m_vd = 1'b0; m_pcd = '0; m_id = '0;
    endtask

    task automatic model_bubble();
        m_vd = 1'b0; m_pcd = '0; m_id = '0;
    endtask

    task automatic model_step(input logic st, input logic rdy, input logic bj, input logic [31:0] tgt);
        logic redir;
        redir = bj && m_vd && !st;
        if (redir) begin
            model_bubble();
            if (m_hold) begin
                m_hold = 1'b0; m_pc = tgt;
            end else if (rdy) begin
                m_pc = tgt; m_pend = 1'b0;
            end else begin
                m_pend = 1'b1; m_ppc = tgt;
            end
        end else if (!m_hold && rdy && m_pend) begin
            model_bubble();
            m_pc = m_ppc; m_pend = 1'b0;
        end else if (!m_hold && rdy) begin
            if (!st) begin
                m_vd = 1'b1; m_pcd = m_pc; m_id = memw(m_pc);
            end else begin
                m_hold = 1'b1; m_bpc = m_pc; m_binstr = memw(m_pc);
            end
            m_pc = m_pc + 32'd4;
        end else if (m_hold) begin
            if (!st) begin
                m_vd = 1'b1; m_pcd = m_bpc; m_id = m_binstr; m_hold = 1'b0;
            end
        end else if (!st) begin
            model_bubble();
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".imemReq"},  {31'b0, imemReq}, {31'b0, !m_hold});
        chk({tag, ".imemAddr"}, imemAddr, m_pc);
        chk({tag, ".valid_D"},  {31'b0, valid_D}, {31'b0, m_vd});
        chk({tag, ".pc_D"},     pc_D, m_pcd);
        chk({tag, ".instr_D"},  instr_D, m_id);
    endtask

    task automatic apply(input logic st, input logic rdy, input logic bj, input logic [31:0] tgt);
        stall_F    = st;
        imemReady  = rdy;
        realBJ_D   = bj;
        targetPC_D = tgt;
        imemData   = rdy ? memw(imemAddr) : $urandom;
        model_step(st, rdy, bj, tgt);
    endtask

    typedef struct {
        logic        stall, ready, bj;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pcd, e_instr;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic s, input logic r, input logic b, input logic [31:0] t,
                                input logic eq, input logic [31:0] ea, input logic ev,
                                input logic [31:0] ep, input logic [31:0] ei);
        vec_t v;
        v.stall = s; v.ready = r; v.bj = b; v.tgt = t;
        v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pcd = ep; v.e_instr = ei;
        return v;
    endfunction

    initial begin
        logic        st, rdy, bj;
        logic [31:0] tgt;

        // Sequential fetch, stall into hold, redirects (ready / not ready / hold), wrap
        tbl[0]  = mk(0, 1, 0, 32'h0,   1, 32'h4,   1, 32'h0,   memw(32'h0));
        tbl[1]  = mk(0, 1, 0, 32'h0,   1, 32'h8,   1, 32'h4,   memw(32'h4));
        tbl[2]  = mk(1, 1, 0, 32'h0,   0, 32'hC,   1, 32'h4,   memw(32'h4));
        tbl[3]  = mk(1, 0, 0, 32'h0,   0, 32'hC,   1, 32'h4,   memw(32'h4));
        tbl[4]  = mk(1, 0, 0, 32'h0,   0, 32'hC,   1, 32'h4,   memw(32'h4));
        tbl[5]  = mk(0, 0, 0, 32'h0,   1, 32'hC,   1, 32'h8,   memw(32'h8));
        tbl[6]  = mk(0, 1, 0, 32'h0,   1, 32'h10,  1, 32'hC,   memw(32'hC));
        tbl[7]  = mk(0, 1, 1, 32'h100, 1, 32'h100, 0, 32'h0,   32'h0);
        tbl[8]  = mk(0, 1, 0, 32'h0,   1, 32'h104, 1, 32'h100, memw(32'h100));
        tbl[9]  = mk(0, 0, 1, 32'h200, 1, 32'h104, 0, 32'h0,   32'h0);
        tbl[10] = mk(0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   32'h0);
        tbl[11] = mk(0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   32'h0);
        tbl[12] = mk(0, 0, 0, 32'h0,   1, 32'h104, 0, 32'h0,   32'h0);
        tbl[13] = mk(0, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0,   32'h0);
        tbl[14] = mk(0, 1, 0, 32'h0,   1, 32'h204, 1, 32'h200, memw(32'h200));
        tbl[15] = mk(1, 1, 0, 32'h0,   0, 32'h208, 1, 32'h200, memw(32'h200));
        tbl[16] = mk(0, 0, 1, 32'h300, 1, 32'h300, 0, 32'h0,   32'h0);
        tbl[17] = mk(0, 1, 0, 32'h0,   1, 32'h304, 1, 32'h300, memw(32'h300));
        tbl[18] = mk(0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        tbl[19] = mk(0, 1, 0, 32'h0,   1, 32'h0,   1, 32'hFFFF_FFFC, memw(32'hFFFF_FFFC));
        tbl[20] = mk(1, 0, 1, 32'h500, 1, 32'h0,   1, 32'hFFFF_FFFC, memw(32'hFFFF_FFFC));
        tbl[21] = mk(0, 1, 0, 32'h0,   1, 32'h4,   1, 32'h0,   memw(32'h0));

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.imemReq",  {31'b0, imemReq}, 32'h0);
        chk("rst.imemAddr", imemAddr, 32'h0);
        chk("rst.valid_D",  {31'b0, valid_D}, 32'h0);
        chk("rst.pc_D",     pc_D, 32'h0);
        chk("rst.instr_D",  instr_D, 32'h0);

        rst_n = 1'b1;
        model_reset();
        #1;
        chk("rel.imemReq",  {31'b0, imemReq}, 32'h1);
        chk("rel.imemAddr", imemAddr, 32'h0);

        for (int i = 0; i < 22; i++) begin
            apply(tbl[i].stall, tbl[i].ready, tbl[i].bj, tbl[i].tgt);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d.imemReq", i),  {31'b0, imemReq}, {31'b0, tbl[i].e_req});
            chk($sformatf("vec%0d.imemAddr", i), imemAddr, tbl[i].e_addr);
            chk($sformatf("vec%0d.valid_D", i),  {31'b0, valid_D}, {31'b0, tbl[i].e_valid});
            chk($sformatf("vec%0d.pc_D", i),     pc_D, tbl[i].e_pcd);
            chk($sformatf("vec%0d.instr_D", i),  instr_D, tbl[i].e_instr);
            check_model($sformatf("vecmodel%0d", i));
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom % 4) == 0;
            rdy = m_hold ? 1'b0 : (($urandom % 3) != 0);
            bj  = ($urandom % 5) == 0;
            tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : $urandom;
            tgt[1:0] = 2'b00;
            apply(st, rdy, bj, tgt);
            @(posedge clk);
            @(negedge clk);
            check_model($sformatf("rnd%0d", c));
        end

        // Reset asserted while a request is outstanding
        apply(1'b0, 1'b0, 1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.imemReq",  {31'b0, imemReq}, 32'h0);
        chk("midrst.imemAddr", imemAddr, 32'h0);
        chk("midrst.valid_D",  {31'b0, valid_D}, 32'h0);
        chk("midrst.instr_D",  instr_D, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        imemReady = 1'b0;
        realBJ_D  = 1'b0;
        model_reset();
        #1;
        check_model("afterrst");
        for (int c = 0; c < 200; c++) begin
            st  = ($urandom % 4) == 0;
            rdy = m_hold ? 1'b0 : (($urandom % 2) != 0);
            bj  = ($urandom % 6) == 0;
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            @(negedge clk);
            apply(st, rdy, bj, tgt);
            @(posedge clk);
            #1;
            check_model($sformatf("post%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
